n_serial_tx: RTL and testbench
==============================

Name: n_serial_tx

Overview:
- Parallel-in, serial-out framed transmitter for n-bit words.
- Accepts a word with a valid/ready handshake, captures it internally, then drives a single-wire serial frame: start bit, n data bits LSB first, stop bit.
- Companion to the n-bit parallel registers. It is the sending end that moves register contents onto a serial line.

Parameters:
- n, 4, data word width in bits (n >= 1).
- CLKS_PER_BIT, 4, clock cycles each serial bit is held on y (>= 1).

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-high reset.
- x  input  n  parallel data word to transmit.
- x_valid  input  1  x holds a word to send.
- x_ready  output  1  transmitter can accept a word this cycle.
- y  output  1  serial line; idles high.
- busy  output  1  a frame is in progress (any state other than IDLE).

Behaviour:
- Reset (asynchronous, takes effect immediately without waiting for clk):
  - state=IDLE; y=1, busy=0, x_ready=1.
  - Shift register, bit counter and cycle counter cleared.
- FSM states: IDLE, START, DATA, PARITY (present only with the feature), STOP.
- Handshake:
  - x_ready=1 only in IDLE.
  - Transfer occurs at the posedge where x_valid=1 and x_ready=1.
  - On transfer, x is captured into an internal n-bit shift register and state goes to START.
  - x_valid while not ready is ignored and not queued.
  - x may change freely after the transfer edge; the frame uses only the captured value.
- Output timing:
  - y is registered.
  - y=0 (start bit) from the first cycle after the transfer edge.
- Bit period: every bit (start, each data bit, parity, stop) is held for exactly CLKS_PER_BIT cycles.
  - A cycle counter runs 0..CLKS_PER_BIT-1.
  - The bit advances when the counter reaches CLKS_PER_BIT-1. The counter then wraps to 0.
- DATA state:
  - y = shift_reg[0].
  - Shift right by one at each bit advance.
  - The bit counter runs 0..n-1; leaving DATA happens on the advance with bit counter = n-1.
- STOP: y=1 for CLKS_PER_BIT cycles, then IDLE.
- Frame length: (n+2)*CLKS_PER_BIT cycles, or (n+3)*CLKS_PER_BIT with parity.
- Back-to-back frames: x_ready rises in the first IDLE cycle. A word accepted in that cycle starts its start bit on the next cycle, so there is a minimum gap of exactly one idle-high cycle between frames.
- busy=1 from the cycle after transfer through the last STOP cycle inclusive.
- Reset mid-frame: frame aborted, y forced to 1 immediately, and the captured word is discarded.
- Counter widths:
  - Cycle counter: $clog2(CLKS_PER_BIT), minimum 1.
  - Bit counter: $clog2(n), minimum 1.
  - No counter may overflow for legal parameters.
- CLKS_PER_BIT=1: one cycle per bit with no stall cycles.

Optional Feature:
- Macro: N_SERIAL_TX_PARITY_EN.
- Defined:
  - A PARITY state between DATA and STOP.
  - y = even parity (XOR of the n captured data bits) for CLKS_PER_BIT cycles.
  - Parity is computed from the word at capture time, not from the shifting register.
- Undefined:
  - No PARITY state; DATA goes directly to STOP.
  - Frame length is (n+2)*CLKS_PER_BIT.

Test Plan:
- Reset/idle: assert reset for 2 cycles with x_valid=0 -> y=1, busy=0, x_ready=1 throughout and after release.
- Single frame, n=10, CLKS_PER_BIT=2: x=10'b1000100010 accepted -> y sequence per bit (2 cycles each) is 0, then 0,1,0,0,0,1,0,0,0,1, then 1; busy high for 24 cycles; x_ready low for the same 24 cycles.
- Input stability: change x to 10'b1110100010 during DATA -> serial output still carries 10'b1000100010.
- Back-to-back: x_valid held high with x=10'b1010100010 then 10'b1001111010 -> second start bit begins exactly one idle-high cycle after the first frame's stop bit ends.
- Mid-frame reset: assert reset in the 5th data bit -> y=1 and busy=0 within the same cycle, not waiting for clk; the next accepted word transmits a full correct frame.
- Parity (macro defined), n=4, CLKS_PER_BIT=1: x=4'b1011 -> y sequence 0,1,1,0,1,1(parity),1(stop); frame length 7 cycles.

Source files
------------

// File: rtl/n_serial_tx.sv
// n_serial_tx: parallel-in, serial-out framed transmitter.
//
// A word is taken with a valid/ready handshake, captured into a shift
// register, and sent on y as: start bit (0), n data bits LSB first,
// [even parity bit], stop bit (1). Each bit is held CLKS_PER_BIT cycles.
//
// Optional feature: define N_SERIAL_TX_PARITY_EN to insert a parity bit
// (XOR of the captured word) between the last data bit and the stop bit.
//
// Ports:
//   clk      rising-edge clock
//   reset    asynchronous, active-high reset
//   x        parallel word to transmit (n bits)
//   x_valid  x holds a word to send
//   x_ready  transmitter accepts a word this cycle (only when idle)
//   y        serial line, registered, idles high
//   busy     a frame is in progress
module n_serial_tx #(
    parameter int n            = 4,
    parameter int CLKS_PER_BIT = 4
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [n-1:0] x,
    input  logic         x_valid,
    output logic         x_ready,
    output logic         y,
    output logic         busy
);

    localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int BW = (n > 1) ? $clog2(n) : 1;

`ifdef N_SERIAL_TX_PARITY_EN
    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
`else
    typedef enum logic [2:0] {IDLE, START, DATA, STOP} state_t;
`endif

    state_t        state;
    logic [n-1:0]  sr;
    logic [n-1:0]  sr_nxt;
    logic [CW-1:0] cnt;
    logic [BW-1:0] bitcnt;
    logic          last;
`ifdef N_SERIAL_TX_PARITY_EN
    logic          par;
`endif

    // Bit period ends on the final cycle of the counter.
    assign last   = (cnt == CW'(CLKS_PER_BIT - 1));
    assign sr_nxt = sr >> 1;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= IDLE;
            sr      <= '0;
            cnt     <= '0;
            bitcnt  <= '0;
            y       <= 1'b1;
            busy    <= 1'b0;
            x_ready <= 1'b1;
`ifdef N_SERIAL_TX_PARITY_EN
            par     <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (x_valid && x_ready) begin
                        sr      <= x;
`ifdef N_SERIAL_TX_PARITY_EN
                        // Parity from the word as captured, not the shifting copy.
                        par     <= ^x;
`endif
                        cnt     <= '0;
                        bitcnt  <= '0;
                        state   <= START;
                        y       <= 1'b0;
                        busy    <= 1'b1;
                        x_ready <= 1'b0;
                    end
                end
                START: begin
                    if (last) begin
                        cnt   <= '0;
                        state <= DATA;
                        y     <= sr[0];
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                DATA: begin
                    if (last) begin
                        cnt <= '0;
                        sr  <= sr_nxt;
                        if (bitcnt == BW'(n - 1)) begin
                            bitcnt <= '0;
`ifdef N_SERIAL_TX_PARITY_EN
                            state  <= PARITY;
                            y      <= par;
`else
                            state  <= STOP;
                            y      <= 1'b1;
`endif
                        end else begin
                            bitcnt <= bitcnt + BW'(1);
                            // Next data bit is bit 0 of the shifted word.
                            y      <= sr_nxt[0];
                        end
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
`ifdef N_SERIAL_TX_PARITY_EN
                PARITY: begin
                    if (last) begin
                        cnt   <= '0;
                        state <= STOP;
                        y     <= 1'b1;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
`endif
                STOP: begin
                    if (last) begin
                        // Ready rises in the first idle cycle, giving exactly
                        // one idle-high cycle between back-to-back frames.
                        cnt     <= '0;
                        state   <= IDLE;
                        busy    <= 1'b0;
                        x_ready <= 1'b1;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                default: begin
                    state   <= IDLE;
                    y       <= 1'b1;
                    busy    <= 1'b0;
                    x_ready <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_n_serial_tx.sv
// Self-checking bench for n_serial_tx. Two instances: A (n=10, 2 clks/bit)
// and B (n=4, 1 clk/bit). Expected line waveforms are built from the frame
// definition as a per-cycle queue of bits.
module tb_n_serial_tx;

    logic       clk = 1'b0;
    logic       reset;
    logic [9:0] xa;
    logic       va;
    logic       ra, ya, ba;
    logic [3:0] xb;
    logic       vb;
    logic       rb, yb, bb;

    int errors = 0;
    int checks = 0;

    n_serial_tx #(.n(10), .CLKS_PER_BIT(2)) u_a (
        .clk(clk), .reset(reset), .x(xa), .x_valid(va),
        .x_ready(ra), .y(ya), .busy(ba)
    );

    n_serial_tx #(.n(4), .CLKS_PER_BIT(1)) u_b (
        .clk(clk), .reset(reset), .x(xb), .x_valid(vb),
        .x_ready(rb), .y(yb), .busy(bb)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input int idx, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s idx=%0d observed=%0h expected=%0h", tag, idx, obs, exp);
        end
    endtask

    function automatic logic rdy(input int which);
        return (which == 0) ? ra : rb;
    endfunction
    function automatic logic yy(input int which);
        return (which == 0) ? ya : yb;
    endfunction
    function automatic logic bsy(input int which);
        return (which == 0) ? ba : bb;
    endfunction

    task automatic drive(input int which, input logic [15:0] w, input logic v);
        if (which == 0) begin
            xa = w[9:0];
            va = v;
        end else begin
            xb = w[3:0];
            vb = v;
        end
    endtask

    // Sends one word and checks every cycle of the frame plus the first idle
    // cycle. 'alt' is driven on x during the frame; with hold set, x_valid
    // stays high throughout (must be ignored) and the next call transfers
    // in the first idle cycle.
    task automatic send(input int which, input logic [15:0] w, input logic [15:0] alt, input bit hold);
        int nb, cpb, guard;
        bit exp_q[$];
        bit p;
        nb  = (which == 0) ? 10 : 4;
        cpb = (which == 0) ? 2 : 1;
        p   = 1'b0;
        repeat (cpb) exp_q.push_back(1'b0);
        for (int i = 0; i < nb; i++) begin
            repeat (cpb) exp_q.push_back(w[i]);
            p = p ^ w[i];
        end
`ifdef N_SERIAL_TX_PARITY_EN
        repeat (cpb) exp_q.push_back(p);
`endif
        repeat (cpb) exp_q.push_back(1'b1);

        guard = 0;
        while (rdy(which) !== 1'b1 && guard < 100) begin
            step();
            guard++;
        end
        chk("ready_wait", which, rdy(which), 1);
        drive(which, w, 1'b1);
        step();
        for (int k = 0; k < exp_q.size(); k++) begin
            drive(which, alt, hold);
            chk("y", k, yy(which), exp_q[k]);
            chk("busy", k, bsy(which), 1);
            chk("x_ready", k, rdy(which), 0);
            step();
        end
        chk("idle_y", which, yy(which), 1);
        chk("idle_busy", which, bsy(which), 0);
        chk("idle_ready", which, rdy(which), 1);
    endtask

    initial begin
        reset = 1'b1;
        xa = '0; va = 1'b0;
        xb = '0; vb = 1'b0;

        // Reset / idle
        #1;
        chk("rst_y", 0, ya, 1);
        chk("rst_busy", 0, ba, 0);
        chk("rst_ready", 0, ra, 1);
        step();
        chk("rst_y", 1, ya, 1);
        chk("rst_busy", 1, ba, 0);
        step();
        reset = 1'b0;
        chk("rel_y", 0, ya, 1);
        chk("rel_ready", 0, ra, 1);
        step();
        chk("rel_y", 1, ya, 1);
        chk("rel_busy", 1, ba, 0);
        chk("rel_ready_b", 1, rb, 1);

        // Single frame; x changes during the frame
        send(0, 16'(10'b1000100010), 16'(10'b1110100010), 1'b0);

        // Back-to-back with x_valid held high
        send(0, 16'(10'b1010100010), 16'(10'b1001111010), 1'b1);
        send(0, 16'(10'b1001111010), 16'h0, 1'b0);

        // Mid-frame reset during the 5th data bit
        drive(0, 16'(10'b1000100010), 1'b1);
        step();
        drive(0, 16'h0, 1'b0);
        repeat (10) step();
        chk("mid_y_before", 0, ya, 0);
        chk("mid_busy_before", 0, ba, 1);
        #2;
        reset = 1'b1;
        #1;
        chk("mid_y_async", 0, ya, 1);
        chk("mid_busy_async", 0, ba, 0);
        chk("mid_ready_async", 0, ra, 1);
        step();
        reset = 1'b0;
        step();
        chk("mid_idle_y", 0, ya, 1);
        send(0, 16'(10'b0110011101), 16'h3ff, 1'b0);

        // Random frames on A
        for (int i = 0; i < 6; i++)
            send(0, 16'($urandom), 16'($urandom), (i % 2) == 1);
        send(0, 16'($urandom), 16'($urandom), 1'b0);

        // B: 1 clk/bit, includes parity frame when enabled
        send(1, 16'(4'b1011), 16'h0, 1'b0);
        for (int i = 0; i < 6; i++)
            send(1, 16'($urandom), 16'($urandom), (i % 2) == 1);
        send(1, 16'(4'b0000), 16'hf, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
